// File: rtl/maze_solve.sv
// -----------------------------------------------------------------------------
// maze_solve
//
// Purpose:
//    Autonomous wall-follower sequencer sitting between the command processor
//    and the navigate block. After every completed move it waits SETTLE_CYC
//    clocks for the IR opening flags to settle, then picks the next action:
//    goal -> DONE, preferred side open -> turn that way, forward open -> move,
//    other side open -> turn that way, otherwise turn around.
//
// Optional feature:
//    MAZE_SOLVE_MV_CNT_EN - when defined, adds an 8-bit saturating count of
//    strt_mv pulses (mv_cnt), cleared when solving is started from IDLE.
//
// Ports:
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    cmd_md     in   command mode; forces IDLE, blocks solving
//    strt_solve in   start pulse (accepted in IDLE and DONE)
//    affinity   in   1 = left-hand rule, 0 = right-hand rule (latched at start)
//    mv_cmplt   in   navigate finished a move or heading change
//    sol_cmplt  in   goal detected
//    lft_opn    in   IR opening to the left
//    rght_opn   in   IR opening to the right
//    frwrd_opn  in   IR opening ahead
//    strt_mv    out  one-cycle move request
//    strt_hdng  out  one-cycle heading-change request
//    stp_lft    out  move stops at left opening (left-hand rule while solving)
//    stp_rght   out  move stops at right opening (right-hand rule while solving)
//    dsrd_hdng  out  desired heading (N/W/S/E encodings only)
//    solving    out  high in MV_WAIT, SETTLE, HDNG_WAIT
//    solved     out  high in DONE
//    mv_cnt     out  move counter (only with MAZE_SOLVE_MV_CNT_EN)
// -----------------------------------------------------------------------------
module maze_solve #(
   parameter int SETTLE_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_md,
   input  logic        strt_solve,
   input  logic        affinity,
   input  logic        mv_cmplt,
   input  logic        sol_cmplt,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        frwrd_opn,
   output logic        strt_mv,
   output logic        strt_hdng,
   output logic        stp_lft,
   output logic        stp_rght,
   output logic [11:0] dsrd_hdng,
   output logic        solving,
   output logic        solved
`ifdef MAZE_SOLVE_MV_CNT_EN
   ,output logic [7:0] mv_cnt
`endif
);

   localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   localparam logic [11:0] HDG_N = 12'h000;
   localparam logic [11:0] HDG_W = 12'h3FF;
   localparam logic [11:0] HDG_S = 12'h7FF;
   localparam logic [11:0] HDG_E = 12'hC00;

   typedef enum logic [2:0] {
      IDLE,
      MV_WAIT,
      SETTLE,
      HDNG_WAIT,
      DONE
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [11:0]   dsrd_hdng_reg;
   logic          aff_reg;
   logic          strt_mv_reg;
   logic          strt_hdng_reg;

   function automatic logic [11:0] turn_left(input logic [11:0] h);
      case (h)
         HDG_N:   turn_left = HDG_W;
         HDG_W:   turn_left = HDG_S;
         HDG_S:   turn_left = HDG_E;
         default: turn_left = HDG_N;
      endcase
   endfunction

   function automatic logic [11:0] turn_right(input logic [11:0] h);
      case (h)
         HDG_N:   turn_right = HDG_E;
         HDG_E:   turn_right = HDG_S;
         HDG_S:   turn_right = HDG_W;
         default: turn_right = HDG_N;
      endcase
   endfunction

   function automatic logic [11:0] turn_back(input logic [11:0] h);
      case (h)
         HDG_N:   turn_back = HDG_S;
         HDG_S:   turn_back = HDG_N;
         HDG_W:   turn_back = HDG_E;
         default: turn_back = HDG_W;
      endcase
   endfunction

   // Wall-follower decision, evaluated from the latched rule. Goal detection
   // takes precedence and is handled in the state machine.
   logic        pref_opn;
   logic        other_opn;
   logic        eval_turn;
   logic [11:0] eval_hdng;

   always_comb begin
      pref_opn  = aff_reg ? lft_opn  : rght_opn;
      other_opn = aff_reg ? rght_opn : lft_opn;
      eval_turn = 1'b1;
      eval_hdng = turn_back(dsrd_hdng_reg);
      if (pref_opn) begin
         eval_hdng = aff_reg ? turn_left(dsrd_hdng_reg) : turn_right(dsrd_hdng_reg);
      end else if (frwrd_opn) begin
         eval_turn = 1'b0;
         eval_hdng = dsrd_hdng_reg;
      end else if (other_opn) begin
         eval_hdng = aff_reg ? turn_right(dsrd_hdng_reg) : turn_left(dsrd_hdng_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         dsrd_hdng_reg <= HDG_N;
         aff_reg       <= 1'b0;
         strt_mv_reg   <= 1'b0;
         strt_hdng_reg <= 1'b0;
      end else begin
         strt_mv_reg   <= 1'b0;
         strt_hdng_reg <= 1'b0;
         if (cmd_md) begin
            // Abort: heading is kept so a later start resumes from it.
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE, DONE: begin
                  if (strt_solve) begin
                     aff_reg     <= affinity;
                     state_reg   <= MV_WAIT;
                     strt_mv_reg <= 1'b1;
                  end
               end
               MV_WAIT: begin
                  // A completion seen alongside our own request is stale.
                  if (mv_cmplt && !strt_mv_reg) begin
                     state_reg <= SETTLE;
                     cnt_reg   <= CW'(SETTLE_CYC);
                  end
               end
               SETTLE: begin
                  if (cnt_reg == '0) begin
                     if (sol_cmplt) begin
                        state_reg <= DONE;
                     end else if (eval_turn) begin
                        dsrd_hdng_reg <= eval_hdng;
                        strt_hdng_reg <= 1'b1;
                        state_reg     <= HDNG_WAIT;
                     end else begin
                        strt_mv_reg <= 1'b1;
                        state_reg   <= MV_WAIT;
                     end
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               HDNG_WAIT: begin
                  if (mv_cmplt && !strt_hdng_reg) begin
                     strt_mv_reg <= 1'b1;
                     state_reg   <= MV_WAIT;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

`ifdef MAZE_SOLVE_MV_CNT_EN
   logic [7:0] mv_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_cnt_reg <= 8'h00;
      end else if (!cmd_md && (state_reg == IDLE) && strt_solve) begin
         mv_cnt_reg <= 8'h00;
      end else if (strt_mv_reg && (mv_cnt_reg != 8'hFF)) begin
         mv_cnt_reg <= mv_cnt_reg + 8'h01;
      end
   end

   assign mv_cnt = mv_cnt_reg;
`endif

   assign solving   = (state_reg == MV_WAIT) || (state_reg == SETTLE) ||
                      (state_reg == HDNG_WAIT);
   assign solved    = (state_reg == DONE);
   assign strt_mv   = strt_mv_reg;
   assign strt_hdng = strt_hdng_reg;
   assign dsrd_hdng = dsrd_hdng_reg;
   assign stp_lft   = solving & aff_reg;
   assign stp_rght  = solving & ~aff_reg;

endmodule

// File: tb/tb_maze_solve.sv
// -----------------------------------------------------------------------------
// tb_maze_solve
//
// Directed bench for maze_solve. Every expected strt_mv / strt_hdng pulse is
// queued (kind, heading, cycle) when its stimulus is driven; a monitor pops
// and compares each pulse the DUT emits. Level outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_maze_solve;

   localparam int SETTLE = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_md = 1'b0;
   logic strt_solve = 1'b0;
   logic affinity = 1'b0;
   logic mv_cmplt = 1'b0;
   logic sol_cmplt = 1'b0;
   logic lft_opn = 1'b0;
   logic rght_opn = 1'b0;
   logic frwrd_opn = 1'b0;

   logic        strt_mv;
   logic        strt_hdng;
   logic        stp_lft;
   logic        stp_rght;
   logic [11:0] dsrd_hdng;
   logic        solving;
   logic        solved;
`ifdef MAZE_SOLVE_MV_CNT_EN
   logic [7:0]  mv_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic        kind;   // 0 = strt_mv, 1 = strt_hdng
      logic [11:0] hdng;
      logic [31:0] at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   maze_solve #(.SETTLE_CYC(SETTLE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_md(cmd_md),
      .strt_solve(strt_solve),
      .affinity(affinity),
      .mv_cmplt(mv_cmplt),
      .sol_cmplt(sol_cmplt),
      .lft_opn(lft_opn),
      .rght_opn(rght_opn),
      .frwrd_opn(frwrd_opn),
      .strt_mv(strt_mv),
      .strt_hdng(strt_hdng),
      .stp_lft(stp_lft),
      .stp_rght(stp_rght),
      .dsrd_hdng(dsrd_hdng),
      .solving(solving),
      .solved(solved)
`ifdef MAZE_SOLVE_MV_CNT_EN
      ,.mv_cnt(mv_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_pulse(input logic kind, input logic [11:0] h, input int at);
      exp_t e;
      e.kind = kind;
      e.hdng = h;
      e.at   = 32'(at);
      sb.push_back(e);
   endtask

   // Pulse monitor: compare each emitted pulse against the scoreboard head.
   always @(negedge clk) begin
      if (strt_mv || strt_hdng) begin
         check("pulse_exclusive", 32'(strt_mv & strt_hdng), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'({strt_hdng, strt_mv}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind", 32'(strt_hdng), 32'(mon_e.kind));
            check("pulse_hdng", 32'(dsrd_hdng), 32'(mon_e.hdng));
            check("pulse_cycle", 32'(cyc), mon_e.at);
         end
      end
   end

   task automatic solve_start(input logic aff, input logic [11:0] h);
      @(negedge clk);
      affinity   = aff;
      strt_solve = 1'b1;
      expect_pulse(1'b0, h, cyc + 1);
      @(negedge clk);
      strt_solve = 1'b0;
   endtask

   // Pulse mv_cmplt with the given openings; in_settle selects whether the
   // resulting pulse comes after the settle delay or on the next cycle.
   task automatic move_done(input logic l, input logic r, input logic f, input logic s,
                            input bit in_settle, input bit want,
                            input logic kind, input logic [11:0] h);
      @(negedge clk);
      lft_opn   = l;
      rght_opn  = r;
      frwrd_opn = f;
      sol_cmplt = s;
      mv_cmplt  = 1'b1;
      if (want) expect_pulse(kind, h, cyc + (in_settle ? SETTLE + 2 : 1));
      @(negedge clk);
      mv_cmplt = 1'b0;
      repeat (in_settle ? SETTLE + 2 : 2) @(negedge clk);
   endtask

   task automatic check_levels(input string tag, input logic lft, input logic rght,
                               input logic slv, input logic sld, input logic [11:0] h);
      check({tag, "_stp_lft"},  32'(stp_lft),   32'(lft));
      check({tag, "_stp_rght"}, 32'(stp_rght),  32'(rght));
      check({tag, "_solving"},  32'(solving),   32'(slv));
      check({tag, "_solved"},   32'(solved),    32'(sld));
      check({tag, "_hdng"},     32'(dsrd_hdng), 32'(h));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_strt_mv",   32'(strt_mv),   32'd0);
      check("rst_strt_hdng", 32'(strt_hdng), 32'd0);
      check_levels("rst", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      rst_n = 1'b1;

      // Left-hand start; a completion during strt_mv is ignored
      solve_start(1'b1, 12'h000);
      check_levels("start_left", 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      mv_cmplt = 1'b1;
      @(negedge clk);
      mv_cmplt = 1'b0;

      // Left turn preferred over forward, then heading complete -> move
      move_done(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3FF);
      check_levels("left_turn", 1'b1, 1'b0, 1'b1, 1'b0, 12'h3FF);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h3FF);

      // Dead ends: W -> E, then E -> W
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'hC00);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hC00);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3FF);

      // Abort in HDNG_WAIT with simultaneous strt_solve
      @(negedge clk);
      cmd_md     = 1'b1;
      strt_solve = 1'b1;
      @(negedge clk);
      check_levels("abort", 1'b0, 1'b0, 1'b0, 1'b0, 12'h3FF);
      @(negedge clk);
      cmd_md     = 1'b0;
      strt_solve = 1'b0;
      check_levels("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0, 12'h3FF);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

      // Right-hand restart from W: forward only keeps heading
      solve_start(1'b0, 12'h3FF);
      check_levels("start_right", 1'b0, 1'b1, 1'b1, 1'b0, 12'h3FF);
      move_done(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h3FF);
      // Both sides open: right wins, W -> N
      move_done(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
`ifdef MAZE_SOLVE_MV_CNT_EN
      check("mv_cnt", 32'(mv_cnt), 32'd3);
`endif
      // Only the other side open: left turn N -> W
      move_done(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3FF);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h3FF);

      // Goal beats open sides; DONE ignores further completions
      move_done(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      check_levels("goal", 1'b0, 1'b0, 1'b0, 1'b1, 12'h3FF);
      move_done(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      check_levels("done_hold", 1'b0, 1'b0, 1'b0, 1'b1, 12'h3FF);
      sol_cmplt = 1'b0;

      // Restart from DONE, then asynchronous reset while strt_mv is high
      @(negedge clk);
      affinity   = 1'b1;
      strt_solve = 1'b1;
      @(posedge clk);
      #1;
      strt_solve = 1'b0;
      check("restart_strt_mv", 32'(strt_mv), 32'd1);
      check_levels("restart", 1'b1, 1'b0, 1'b1, 1'b0, 12'h3FF);
      rst_n = 1'b0;
      #1;
      check("arst_strt_mv", 32'(strt_mv), 32'd0);
      check_levels("arst", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
